// File: rtl/frame_loader.sv
// frame_loader: copies a completed frame from next_target_frame into target_frame,
// one word per clock, together with its transition time. A copy starts only on a
// driver latch boundary (i_drq) and only while the animator is not reading
// target_frame. o_frame_ack and o_swap pulse together once the last word is written.
//
// Optional build macro: FRAME_LOADER_TIMEOUT_EN adds a WAIT-state watchdog
// (c_timeout parameter, sticky o_timeout port). Without it WAIT waits indefinitely.
module frame_loader #(
    parameter int unsigned c_ledboards = 30,
    parameter int unsigned c_bpc       = 12,
    parameter int unsigned c_max_time  = 1024,
`ifdef FRAME_LOADER_TIMEOUT_EN
    parameter int unsigned c_timeout   = 4096,
`endif
    localparam int unsigned c_channels = c_ledboards * 32,
    localparam int unsigned c_addr_w   = $clog2(c_channels),
    localparam int unsigned c_time_w   = $clog2(c_max_time)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_frame_valid,
    output logic                o_frame_ack,
    input  logic                i_drq,
    input  logic                i_anim_busy,
    output logic [c_addr_w-1:0] o_src_raddr,
    input  logic [c_bpc-1:0]    i_src_rdata,
    input  logic [c_time_w-1:0] i_src_time,
    output logic                o_dst_wen,
    output logic [c_addr_w-1:0] o_dst_waddr,
    output logic [c_bpc-1:0]    o_dst_wdata,
    output logic [c_time_w-1:0] o_dst_time,
    output logic                o_busy,
`ifdef FRAME_LOADER_TIMEOUT_EN
    output logic                o_timeout,
`endif
    output logic                o_swap
);

    typedef enum logic [2:0] {StIdle, StArmed, StWait, StCopy, StDone} state_e;

    localparam logic [c_addr_w-1:0] c_last = c_addr_w'(c_channels - 1);

    state_e              state_q;
    logic [c_addr_w-1:0] rd_q;
    logic [c_addr_w-1:0] waddr_q;
    logic                wen_q;
    logic                ack_q;
    logic                swap_q;
    logic                busy_q;
    logic [c_time_w-1:0] time_q;

`ifdef FRAME_LOADER_TIMEOUT_EN
    localparam int unsigned       c_cnt_w    = (c_timeout > 1) ? $clog2(c_timeout) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_timeout - 1);

    logic [c_cnt_w-1:0] wait_cnt_q;
    logic               timeout_q;
`endif

    // Sequencer: handshake with host, wait for latch boundary and idle animator, then copy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            rd_q       <= '0;
            waddr_q    <= '0;
            wen_q      <= 1'b0;
            ack_q      <= 1'b0;
            swap_q     <= 1'b0;
            busy_q     <= 1'b0;
            time_q     <= '0;
`ifdef FRAME_LOADER_TIMEOUT_EN
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            ack_q  <= 1'b0;
            swap_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A drq arriving together with valid is deliberately not consumed.
                    if (i_frame_valid) begin
                        state_q <= StArmed;
                        busy_q  <= 1'b1;
                    end
                end
                StArmed: begin
                    if (!i_frame_valid) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (i_drq) begin
                        // Always pass through WAIT for at least one cycle.
                        state_q    <= StWait;
`ifdef FRAME_LOADER_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                StWait: begin
`ifdef FRAME_LOADER_TIMEOUT_EN
                    if (!i_anim_busy || wait_cnt_q == c_cnt_last) begin
                        state_q <= StCopy;
                        rd_q    <= '0;
                        time_q  <= i_src_time;
                        if (i_anim_busy) begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + c_cnt_w'(1);
                    end
`else
                    if (!i_anim_busy) begin
                        state_q <= StCopy;
                        rd_q    <= '0;
                        time_q  <= i_src_time;
                    end
`endif
                end
                StCopy: begin
                    // Write side trails the read address by the source's 1-cycle latency.
                    if (wen_q && waddr_q == c_last) begin
                        state_q <= StDone;
                        wen_q   <= 1'b0;
                        waddr_q <= '0;
                        rd_q    <= '0;
                        busy_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        swap_q  <= 1'b1;
                    end else begin
                        wen_q   <= 1'b1;
                        waddr_q <= rd_q;
                        if (rd_q != c_last) begin
                            rd_q <= rd_q + c_addr_w'(1);
                        end
                    end
                end
                StDone: begin
                    // A valid still high here is taken as a fresh frame.
                    if (i_frame_valid) begin
                        state_q <= StArmed;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    wen_q   <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; data and time are forced to 0 when no write is in progress.
    always_comb begin
        o_frame_ack = ack_q;
        o_swap      = swap_q;
        o_busy      = busy_q;
        o_src_raddr = rd_q;
        o_dst_wen   = wen_q;
        o_dst_waddr = waddr_q;
        o_dst_wdata = wen_q ? i_src_rdata : '0;
        o_dst_time  = wen_q ? time_q : '0;
`ifdef FRAME_LOADER_TIMEOUT_EN
        o_timeout   = timeout_q;
`endif
    end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Sequencer that copies a completed frame from next_target_frame into target_frame, one word per clock, together with its transition time.
- Copy starts only on a driver latch boundary, and only while the animator is not walking target_frame, so the animator never reads a half-updated target.
- Sits between the host-facing write side (next_target_frame) and the animator.
- Pulses o_swap after each copy so the animator restarts its transition.

Parameters:
- c_ledboards, 30, number of LED boards; c_channels = c_ledboards*32, c_addr_w = $clog2(c_channels)
- c_bpc, 12, bits per colour channel (data width)
- c_max_time, 1024, transition time range; c_time_w = $clog2(c_max_time)
- c_timeout, 4096, WAIT-state watchdog limit in clocks (used only with FRAME_LOADER_TIMEOUT_EN)

Ports:
- i_clk  in  1  block clock (divided 2 MHz domain)
- i_rst  in  1  synchronous reset, active-high
- i_frame_valid  in  1  level; host has finished writing next_target_frame
- o_frame_ack  out  1  one-cycle pulse; frame consumed, host may rewrite source
- i_drq  in  1  driver latch pulse (frame boundary)
- i_anim_busy  in  1  animator currently reading target_frame
- o_src_raddr  out  c_addr_w  read address to next_target_frame
- i_src_rdata  in  c_bpc  read data, 1-cycle registered latency
- i_src_time  in  c_time_w  transition time stored with source frame
- o_dst_wen  out  1  write enable to target_frame
- o_dst_waddr  out  c_addr_w  write address to target_frame
- o_dst_wdata  out  c_bpc  write data to target_frame
- o_dst_time  out  c_time_w  time to target_frame, valid while o_dst_wen=1
- o_busy  out  1  high in ARMED, WAIT, COPY
- o_swap  out  1  one-cycle pulse; new target frame complete
- o_timeout  out  1  sticky watchdog flag (FRAME_LOADER_TIMEOUT_EN only)

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset has priority over every other input.
- IDLE: when i_frame_valid=1, go to ARMED.
- ARMED:
  - i_frame_valid=0 → IDLE (host abort, no ack).
  - Else i_drq=1 → WAIT.
- WAIT:
  - i_anim_busy=0 → COPY. Capture i_src_time into the time register and set read pointer rd=0.
  - i_frame_valid is ignored from WAIT onward.
- COPY:
  - Each cycle: o_src_raddr=rd, then rd increments.
  - One cycle later: o_dst_wen=1, o_dst_waddr=previous rd, o_dst_wdata=i_src_rdata, o_dst_time=captured time.
  - rd stops at c_channels-1; no wrap.
  - Go to DONE after the write of address c_channels-1.
  - Total duration: exactly c_channels+1 cycles from COPY entry to the last write, inclusive.
  - i_drq and i_anim_busy are ignored during COPY.
- DONE (1 cycle):
  - o_frame_ack=1 and o_swap=1 in the same cycle.
  - Then IDLE, or ARMED directly if i_frame_valid is still high. The host must drop valid in the ack cycle; a still-high valid is treated as a new frame.
- o_src_raddr is 0 outside COPY.
- o_dst_wen is never high outside COPY or the single trailing write cycle.
- Simultaneous events:
  - i_frame_valid rising together with i_drq in IDLE: the drq is not consumed; the next drq is required.
  - i_drq and i_anim_busy=0 in the same cycle in ARMED: WAIT is still entered for one cycle (minimum 1 cycle in WAIT).
- Reset mid-COPY: o_dst_wen=0 on the cycle after reset is asserted; target_frame is left partially written; no ack, no swap.

Optional Feature:
- FRAME_LOADER_TIMEOUT_EN defined:
  - A WAIT-state counter increments each cycle i_anim_busy=1.
  - On reaching c_timeout-1, go to COPY regardless of i_anim_busy and set o_timeout=1.
  - o_timeout stays set until i_rst. The counter clears on WAIT entry.
- Not defined: no counter, no o_timeout port; WAIT waits indefinitely.

Test Plan:
- c_ledboards=1 (32 words), source filled with addr*3, i_src_time=100; valid, drq, busy=0 → 32 writes, waddr 0..31, wdata = 3*waddr, time=100; first write 1 cycle after COPY entry; ack+swap single pulse one cycle after last write.
- Valid raised, dropped before any drq → returns to IDLE; no writes, no ack; o_busy drops the cycle after valid low.
- Valid, drq, busy held high 50 cycles then low → zero writes during busy; copy starts the cycle after busy falls; drq pulses during the copy have no effect.
- Reset asserted at the 10th write → o_dst_wen low next cycle, all outputs 0; no ack/swap; a subsequent valid+drq performs a full 32-word copy.
- Valid held high through ack → second copy occurs only after the next drq; exactly two acks.
- With FRAME_LOADER_TIMEOUT_EN, c_timeout=16, busy stuck high → COPY entered 16 cycles after WAIT entry; o_timeout=1 and stays 1 through a later normal copy.
